// File: rtl/sb_param_cfg_pkg.sv
// Shared definitions for the parameterised switch block: routing-mux
// select encodings and the configuration-control FSM state type.
package sb_param_cfg_pkg;

    // 2-bit select encoding used by every routing mux
    localparam logic [1:0] SEL_OFF      = 2'd0;  // drive constant 0
    localparam logic [1:0] SEL_STRAIGHT = 2'd1;  // same-index track of the other channel
    localparam logic [1:0] SEL_DIAG     = 2'd2;  // next-index track (wraps) of the other channel
    localparam logic [1:0] SEL_PIN      = 2'd3;  // grid pin, index folded by GRID_PINS

    // Configuration-load progress: IDLE (nothing shifted), LOADING (partial),
    // READY (exactly one full word), OVER (too many bits, needs reset)
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_READY   = 2'd2,
        ST_OVER    = 2'd3
    } cfg_state_t;

endpackage

// File: rtl/sb_param_mux4.sv
// One 4:1 routing mux of the switch block, controlled by a 2-bit select.
module sb_param_mux4
    import sb_param_cfg_pkg::*;
(
    input  logic [1:0] sel,
    input  logic       straight,
    input  logic       diag,
    input  logic       pin,
    output logic       out
);

    // Pick the source named by the select code; SEL_OFF yields 0
    always_comb begin
        out = 1'b0;
        case (sel)
            SEL_STRAIGHT: out = straight;
            SEL_DIAG:     out = diag;
            SEL_PIN:      out = pin;
            default:      out = 1'b0;
        endcase
    end

endmodule

// File: rtl/sb_param_cfg.sv
// Parameterised switch block with a shadow/active configuration pair.
// Configuration is shifted serially into the shadow register and only
// copied to the active register by a commit that follows an exact-length
// load, so the routing never glitches while a new word is being shifted.
module sb_param_cfg
    import sb_param_cfg_pkg::*;
#(
    parameter int CHAN_W    = 5,
    parameter int GRID_PINS = 2
) (
    input  logic                 prog_clk,
    input  logic                 pReset,
    input  logic [CHAN_W-1:0]    chany_bottom_in,
    input  logic [CHAN_W-1:0]    chanx_left_in,
    input  logic [GRID_PINS-1:0] bottom_grid_pin,
    input  logic [GRID_PINS-1:0] left_grid_pin,
    input  logic                 ccff_head,
    input  logic                 cfg_shift,
    input  logic                 cfg_commit,
    output logic [CHAN_W-1:0]    chany_bottom_out,
    output logic [CHAN_W-1:0]    chanx_left_out,
    output logic                 ccff_tail,
    output logic                 cfg_full,
    output logic                 cfg_err
);

    // Two select bits per output mux, 2*CHAN_W muxes
    localparam int CFG_BITS = 4 * CHAN_W;
    // Counter must reach CFG_BITS+1 (overshift marker)
    localparam int CNT_W    = $clog2(CFG_BITS + 2);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(CFG_BITS + 1);

    logic [CFG_BITS-1:0] shadow_reg;
    logic [CFG_BITS-1:0] active_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                err_reg;
    cfg_state_t          state_reg;
    cfg_state_t          state_next;
    logic                commit_ok;

    // A commit is honoured only on an idle-shift cycle with exactly one full word loaded
    assign commit_ok = cfg_commit & ~cfg_shift & cfg_full;

    assign cfg_full  = (cnt_reg == CNT_FULL);
    assign ccff_tail = shadow_reg[CFG_BITS-1];
    assign cfg_err   = err_reg;

    // Serial shadow chain: new bit enters at LSB, MSB feeds the next block
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            shadow_reg <= '0;
        end else if (cfg_shift) begin
            shadow_reg <= {shadow_reg[CFG_BITS-2:0], ccff_head};
        end
    end

    // Bit counter: counts shifts, sticks at the overshift value, clears on a good commit
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            cnt_reg <= '0;
        end else if (cfg_shift) begin
            if (cnt_reg != CNT_OVER) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end else if (commit_ok) begin
            cnt_reg <= '0;
        end
    end

    // Active configuration only ever changes on a valid commit
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            active_reg <= '0;
        end else if (commit_ok) begin
            active_reg <= shadow_reg;
        end
    end

    // Sticky rejected-commit flag, cleared by the next accepted commit
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            err_reg <= 1'b0;
        end else if (commit_ok) begin
            err_reg <= 1'b0;
        end else if (cfg_commit) begin
            err_reg <= 1'b1;
        end
    end

    // Control FSM state register
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic tracking load progress; OVER is left only via reset
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cfg_shift) state_next = ST_LOADING;
            end
            ST_LOADING: begin
                if (cfg_shift && (cnt_reg == CNT_LAST)) state_next = ST_READY;
            end
            ST_READY: begin
                if (cfg_shift)      state_next = ST_OVER;
                else if (commit_ok) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_OVER;
            end
        endcase
    end

    // Routing muxes: index gi drives bottom output gi, index gi+CHAN_W drives left output gi
    genvar gi;
    generate
        for (gi = 0; gi < CHAN_W; gi++) begin : g_mux
            sb_param_mux4 u_bottom (
                .sel      (active_reg[2*gi+1 -: 2]),
                .straight (chanx_left_in[gi]),
                .diag     (chanx_left_in[(gi+1) % CHAN_W]),
                .pin      (bottom_grid_pin[gi % GRID_PINS]),
                .out      (chany_bottom_out[gi])
            );
            sb_param_mux4 u_left (
                .sel      (active_reg[2*(gi+CHAN_W)+1 -: 2]),
                .straight (chany_bottom_in[gi]),
                .diag     (chany_bottom_in[(gi+1) % CHAN_W]),
                .pin      (left_grid_pin[gi % GRID_PINS]),
                .out      (chanx_left_out[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_sb_param_cfg.sv
// Scoreboard bench for sb_param_cfg (CHAN_W=5, GRID_PINS=2, CFG_BITS=20).
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_sb_param_cfg;
    import sb_param_cfg_pkg::*;

    logic       prog_clk = 1'b0;
    logic       pReset;
    logic [4:0] chany_bottom_in;
    logic [4:0] chanx_left_in;
    logic [1:0] bottom_grid_pin;
    logic [1:0] left_grid_pin;
    logic       ccff_head;
    logic       cfg_shift;
    logic       cfg_commit;
    logic [4:0] chany_bottom_out;
    logic [4:0] chanx_left_out;
    logic       ccff_tail;
    logic       cfg_full;
    logic       cfg_err;

    sb_param_cfg #(.CHAN_W(5), .GRID_PINS(2)) dut (
        .prog_clk         (prog_clk),
        .pReset           (pReset),
        .chany_bottom_in  (chany_bottom_in),
        .chanx_left_in    (chanx_left_in),
        .bottom_grid_pin  (bottom_grid_pin),
        .left_grid_pin    (left_grid_pin),
        .ccff_head        (ccff_head),
        .cfg_shift        (cfg_shift),
        .cfg_commit       (cfg_commit),
        .chany_bottom_out (chany_bottom_out),
        .chanx_left_out   (chanx_left_out),
        .ccff_tail        (ccff_tail),
        .cfg_full         (cfg_full),
        .cfg_err          (cfg_err)
    );

    always #5 prog_clk = ~prog_clk;

    typedef struct {
        logic [4:0] bot;
        logic [4:0] left;
        logic       full;
        logic       err;
        cfg_state_t st;
        logic       tail_en;
        logic       tail;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    // Monitor: compare every queued expectation against the settled outputs
    always @(negedge prog_clk) begin
        exp_t  e;
        string nm;
        logic  ok;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            ok = (chany_bottom_out === e.bot) && (chanx_left_out === e.left) &&
                 (cfg_full === e.full) && (cfg_err === e.err) &&
                 (dut.state_reg === e.st) && (!e.tail_en || (ccff_tail === e.tail));
            n_checks++;
            if (ok) begin
                n_pass++;
                $display("check %s ok: bot=%b left=%b full=%b err=%b tail=%b st=%0d",
                         nm, chany_bottom_out, chanx_left_out, cfg_full, cfg_err, ccff_tail, dut.state_reg);
            end else begin
                $display("FAIL %s: got bot=%b left=%b full=%b err=%b tail=%b st=%0d; want bot=%b left=%b full=%b err=%b tail=%b(en=%b) st=%0d",
                         nm, chany_bottom_out, chanx_left_out, cfg_full, cfg_err, ccff_tail, dut.state_reg,
                         e.bot, e.left, e.full, e.err, e.tail, e.tail_en, e.st);
            end
        end
    end

    task automatic expect_chk(input string nm, input logic [4:0] b, input logic [4:0] l,
                              input logic f, input logic er, input cfg_state_t s,
                              input logic te, input logic t);
        exp_t e;
        e.bot = b; e.left = l; e.full = f; e.err = er; e.st = s; e.tail_en = te; e.tail = t;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge prog_clk);
        #1;
    endtask

    task automatic shift_one(input logic b);
        cfg_shift = 1'b1;
        ccff_head = b;
        @(posedge prog_clk);
        #1;
        cfg_shift = 1'b0;
        ccff_head = 1'b0;
    endtask

    // Shift w[hi] first down to w[lo]
    task automatic shift_bits(input logic [39:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) shift_one(w[i]);
    endtask

    task automatic do_commit();
        cfg_commit = 1'b1;
        @(posedge prog_clk);
        #1;
        cfg_commit = 1'b0;
    endtask

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] cfg_straight = 40'h55555;    // all muxes SEL_STRAIGHT
        logic [39:0] cfg_diagpin  = 40'hFFEAA;    // bottom SEL_DIAG, left SEL_PIN
        logic [39:0] cfg_mixed    = 40'hD8DE4;    // per-mux mixed selects
        logic [39:0] pat          = 40'hA5C396F01E;
        logic        exp_tail;
        logic        exp_full;
        cfg_state_t  exp_st;

        // Reset with all data inputs at 1
        pReset = 1'b0; cfg_shift = 1'b0; cfg_commit = 1'b0; ccff_head = 1'b1;
        chanx_left_in = '1; chany_bottom_in = '1; bottom_grid_pin = '1; left_grid_pin = '1;
        repeat (2) @(posedge prog_clk);
        #1;
        expect_chk("reset_hold", 5'b0, 5'b0, 1'b0, 1'b0, ST_IDLE, 1'b1, 1'b0);
        pReset = 1'b1;
        @(posedge prog_clk);
        #1;
        expect_chk("after_reset_all_ones", 5'b0, 5'b0, 1'b0, 1'b0, ST_IDLE, 1'b1, 1'b0);

        // Full straight load and commit
        chanx_left_in = 5'b10110; chany_bottom_in = 5'b01101;
        shift_bits(cfg_straight, 19, 0);
        expect_chk("straight_loaded_full", 5'b0, 5'b0, 1'b1, 1'b0, ST_READY, 1'b0, 1'b0);
        do_commit();
        expect_chk("straight_active", 5'b10110, 5'b01101, 1'b0, 1'b0, ST_IDLE, 1'b0, 1'b0);
        chanx_left_in = 5'b01001; chany_bottom_in = 5'b11010;
        expect_chk("straight_follows_inputs", 5'b01001, 5'b11010, 1'b0, 1'b0, ST_IDLE, 1'b0, 1'b0);

        // Undershift commit rejected, then completed load accepted
        bottom_grid_pin = 2'b01; left_grid_pin = 2'b10;
        shift_bits(cfg_diagpin, 19, 10);
        expect_chk("half_loaded", 5'b01001, 5'b11010, 1'b0, 1'b0, ST_LOADING, 1'b0, 1'b0);
        do_commit();
        expect_chk("undershift_commit_rejected", 5'b01001, 5'b11010, 1'b0, 1'b1, ST_LOADING, 1'b0, 1'b0);
        shift_bits(cfg_diagpin, 9, 0);
        expect_chk("second_half_full", 5'b01001, 5'b11010, 1'b1, 1'b1, ST_READY, 1'b0, 1'b0);
        do_commit();
        expect_chk("diag_pin_active", 5'b10100, 5'b01010, 1'b0, 1'b0, ST_IDLE, 1'b0, 1'b0);

        // Overshift: 21 bits, commit rejected, reset recovers
        shift_bits(40'h0, 20, 0);
        expect_chk("overshift", 5'b10100, 5'b01010, 1'b0, 1'b0, ST_OVER, 1'b0, 1'b0);
        do_commit();
        expect_chk("over_commit_rejected", 5'b10100, 5'b01010, 1'b0, 1'b1, ST_OVER, 1'b0, 1'b0);
        pReset = 1'b0;
        expect_chk("reset_from_over", 5'b0, 5'b0, 1'b0, 1'b0, ST_IDLE, 1'b1, 1'b0);
        pReset = 1'b1;

        // Reset during a partial load discards it
        shift_bits(40'h7F, 6, 0);
        cfg_shift = 1'b1; ccff_head = 1'b1; pReset = 1'b0;
        expect_chk("reset_mid_shift", 5'b0, 5'b0, 1'b0, 1'b0, ST_IDLE, 1'b1, 1'b0);
        cfg_shift = 1'b0; ccff_head = 1'b0; pReset = 1'b1;

        // Commit together with the 20th shift is rejected, next-cycle commit valid
        chanx_left_in = 5'b10110; chany_bottom_in = 5'b00111;
        bottom_grid_pin = 2'b10; left_grid_pin = 2'b01;
        shift_bits(cfg_mixed, 19, 1);
        expect_chk("mixed_19_bits", 5'b0, 5'b0, 1'b0, 1'b0, ST_LOADING, 1'b0, 1'b0);
        cfg_commit = 1'b1;
        shift_one(cfg_mixed[0]);
        cfg_commit = 1'b0;
        expect_chk("commit_with_last_shift", 5'b0, 5'b0, 1'b1, 1'b1, ST_READY, 1'b0, 1'b0);
        do_commit();
        expect_chk("mixed_active", 5'b11010, 5'b10001, 1'b0, 1'b0, ST_IDLE, 1'b1, 1'b1);

        // Chain: bit entering ccff_head leaves on ccff_tail 20 shifts later; routing stable
        for (int m = 1; m <= 40; m++) begin
            shift_one(pat[40-m]);
            exp_tail = (m < 20) ? cfg_mixed[19-m] : pat[59-m];
            exp_full = (m == 20);
            exp_st   = (m < 20) ? ST_LOADING : ((m == 20) ? ST_READY : ST_OVER);
            expect_chk($sformatf("chain_shift_%0d", m), 5'b11010, 5'b10001,
                       exp_full, 1'b0, exp_st, 1'b1, exp_tail);
        end

        @(negedge prog_clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
